// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm_pkg: shared encodings and constants for the cache miss fill engine
package cache_fill_fsm_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10
    } state_t;
    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
    localparam int BLOCK_WORDS = 8;
    localparam logic TGT_D = 1'b1;
    localparam logic TGT_I = 1'b0;
endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// fill_counter: 3-bit word counter with sync clear, enable and terminal-count flag built from dff cells
module dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    // single storage bit, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else q <= d;
endmodule

module fill_counter #(
    parameter int LAST = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] count,
    output logic       tc
);
    logic [2:0] nxt;
    // counting past the last word wraps to 0, ready for the next block
    assign nxt = clr ? 3'd0 : en ? count + 3'd1 : count;
    assign tc = count == 3'(LAST);
    for (genvar i = 0; i < 3; i++) begin : g_bit
        dff u_dff (.clk(clk), .rst(rst), .d(nxt[i]), .q(count[i]));
    end
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a missing 16-byte block from pipelined memory into the I- or D-cache
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = cache_fill_fsm_pkg::BLOCK_WORDS,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    output logic        mem_enable,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_data_valid,
    output logic        stall_data_miss,
    output logic        stall_inst_miss,
    output logic        fill_target,
    output logic [2:0]  fill_word_idx,
    output logic [15:0] fill_data,
    output logic        data_array_we,
    output logic        tag_array_we,
    output logic        fsm_busy
);
    import cache_fill_fsm_pkg::*;

    // the counters are 3 bits wide, so only an 8-word block fits; memory must have nonzero latency
    if (BLOCK_WORDS != 8 || MEM_LATENCY < 1) begin : g_bad_params
        $error("cache_fill_fsm: unsupported BLOCK_WORDS/MEM_LATENCY");
    end

    state_t      state;
    logic        target;
    logic [15:0] base;
    logic [2:0]  issue_cnt;
    logic [2:0]  recv_cnt;
    logic        issue_last;
    logic        recv_last;

    assign fsm_busy = state != IDLE;
    assign mem_enable = state == ISSUE;
    assign mem_addr = mem_enable ? base + {12'd0, issue_cnt, 1'b0} : 16'd0;
    // returns arriving in IDLE (e.g. stragglers after a reset) are dropped
    assign data_array_we = fsm_busy & mem_data_valid;
    assign tag_array_we = data_array_we & recv_last;
    assign fill_data = data_array_we ? mem_data : 16'd0;
    assign fill_word_idx = recv_cnt;
    assign fill_target = target;
    assign stall_data_miss = d_miss | (fsm_busy & target);
    assign stall_inst_miss = i_miss | (fsm_busy & ~target);

    fill_counter #(.LAST(BLOCK_WORDS - 1)) u_issue_cnt (
        .clk(clk), .rst(rst), .clr(~fsm_busy), .en(mem_enable),
        .count(issue_cnt), .tc(issue_last)
    );

    fill_counter #(.LAST(BLOCK_WORDS - 1)) u_recv_cnt (
        .clk(clk), .rst(rst), .clr(~fsm_busy), .en(data_array_we),
        .count(recv_cnt), .tc(recv_last)
    );

    // accept a miss (D before I), issue all reads, then wait for the last return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            target <= TGT_I;
            base   <= 16'd0;
        end else begin
            case (state)
                IDLE:
                    if (d_miss) begin
                        base   <= d_miss_addr & BLOCK_MASK;
                        target <= TGT_D;
                        state  <= ISSUE;
                    end else if (i_miss) begin
                        base   <= i_miss_addr & BLOCK_MASK;
                        target <= TGT_I;
                        state  <= ISSUE;
                    end
                ISSUE:
                    if (tag_array_we) state <= IDLE;
                    else if (issue_last) state <= DRAIN;
                DRAIN:
                    if (tag_array_we) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
